// File: rtl/dcm_lock_seq.sv
// DCM_SP reset/lock sequencer (CLKIN_IN domain).
// Holds DCM reset, waits for lock, settles, then releases system reset.
module dcm_lock_seq #(
  parameter int RST_HOLD_CYCLES = 3,
  parameter int LOCK_TIMEOUT    = 10000,
  parameter int SETTLE_CYCLES   = 16,
  parameter int MAX_RETRIES     = 7,
  parameter int CNT_W           = 16
) (
  input  logic       CLKIN_IN,
  input  logic       RST_IN,
  input  logic       LOCKED_IN,
  input  logic [7:0] STATUS_IN,
  input  logic       RETRY_REQ_IN,
  output logic       DCM_RST_OUT,
  output logic       SYS_RST_OUT,
  output logic       READY_OUT,
  output logic       FAIL_OUT,
  output logic [3:0] RETRY_CNT_OUT,
  output logic [7:0] LOSS_CNT_OUT,
  output logic [2:0] STATE_OUT
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that sees lock counts as the
  // first settle cycle, so SETTLE itself lasts one less.
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam bit SET_SKIP = (SETTLE_CYCLES <= 1);
  localparam logic [3:0] RETRY_MAX =
    4'((MAX_RETRIES > 15) ? 15 : MAX_RETRIES);

  logic             lk_m;
  logic             lk_s;
  logic             fx_m;
  logic             fx_s;
  logic             lock_ok;
  logic             unused_status;

  state_t           state_q;
  state_t           nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             fail_ev;

  assign unused_status =
    ^{STATUS_IN[7:3], STATUS_IN[1:0]};

  assign lock_ok   = lk_s & ~fx_s;
  assign STATE_OUT = state_q;

  // Two-flop synchronizers for LOCKED and CLKFX-stopped.
  always_ff @(posedge CLKIN_IN or posedge RST_IN) begin
    if (RST_IN) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
      fx_m <= 1'b0;
      fx_s <= 1'b0;
    end else begin
      lk_m <= LOCKED_IN;
      lk_s <= lk_m;
      fx_m <= STATUS_IN[2];
      fx_s <= fx_m;
    end
  end

  // Next-state, counter and retry/loss bookkeeping.
  always_comb begin
    nxt       = S_HOLD;
    cnt_nxt   = '0;
    retry_nxt = RETRY_CNT_OUT;
    loss_nxt  = LOSS_CNT_OUT;
    fail_ev   = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          nxt = S_WAIT;
        end else begin
          nxt     = S_HOLD;
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_ok) begin
          nxt = SET_SKIP ? S_RUN : S_SETTLE;
        end else if (cnt_q == WAIT_LAST) begin
          fail_ev = 1'b1;
        end else begin
          nxt     = S_WAIT;
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lock_ok) begin
          fail_ev = 1'b1;
        end else if (cnt_q == SET_LAST) begin
          nxt = S_RUN;
        end else begin
          nxt     = S_SETTLE;
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_ok) begin
          fail_ev = 1'b1;
          if (LOSS_CNT_OUT != 8'hFF) begin
            loss_nxt = LOSS_CNT_OUT + 8'd1;
          end
        end else begin
          nxt = S_RUN;
        end
      end
      S_FAIL: begin
        if (RETRY_REQ_IN) begin
          nxt       = S_HOLD;
          retry_nxt = '0;
        end else begin
          nxt = S_FAIL;
        end
      end
      default: begin
        nxt = S_HOLD;
      end
    endcase
    if (fail_ev) begin
      if (RETRY_CNT_OUT == RETRY_MAX) begin
        nxt = S_FAIL;
      end else begin
        nxt = S_HOLD;
        if (RETRY_CNT_OUT != 4'hF) begin
          retry_nxt = RETRY_CNT_OUT + 4'd1;
        end
      end
    end
    if (nxt == S_RUN && state_q != S_RUN) begin
      retry_nxt = '0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLKIN_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      RETRY_CNT_OUT <= '0;
      LOSS_CNT_OUT  <= '0;
      DCM_RST_OUT   <= 1'b1;
      SYS_RST_OUT   <= 1'b1;
      READY_OUT     <= 1'b0;
      FAIL_OUT      <= 1'b0;
    end else begin
      state_q       <= nxt;
      cnt_q         <= cnt_nxt;
      RETRY_CNT_OUT <= retry_nxt;
      LOSS_CNT_OUT  <= loss_nxt;
      DCM_RST_OUT   <= (nxt == S_HOLD) ||
                       (nxt == S_FAIL);
      SYS_RST_OUT   <= (nxt != S_RUN);
      READY_OUT     <= (nxt == S_RUN);
      FAIL_OUT      <= (nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_dcm_lock_seq.sv
// Bench for dcm_lock_seq: directed scenarios plus
// randomized lock/status traffic against a reference model.
module tb_dcm_lock_seq;

  localparam int RH = 3;
  localparam int LT = 20;
  localparam int SC = 4;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic [7:0] status = 8'h00;
  logic       retry_req = 1'b0;
  logic       dcm_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail_flag;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  dcm_lock_seq #(
    .RST_HOLD_CYCLES(RH),
    .LOCK_TIMEOUT(LT),
    .SETTLE_CYCLES(SC),
    .MAX_RETRIES(MR),
    .CNT_W(16)
  ) dut (
    .CLKIN_IN(clk),
    .RST_IN(rst),
    .LOCKED_IN(locked),
    .STATUS_IN(status),
    .RETRY_REQ_IN(retry_req),
    .DCM_RST_OUT(dcm_rst),
    .SYS_RST_OUT(sys_rst),
    .READY_OUT(ready),
    .FAIL_OUT(fail_flag),
    .RETRY_CNT_OUT(retry_cnt),
    .LOSS_CNT_OUT(loss_cnt),
    .STATE_OUT(state)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycles spent in phase,
  // consecutive-lock streak, retries, losses, and the
  // two-cycle input delay line of the synchronizer.
  int m_ph, m_el, m_st, m_rt, m_ls;
  bit h1l, h2l, h1s, h2s;

  function automatic void m_failure();
    if (m_rt == MR) m_ph = 4;
    else begin
      m_ph = 0;
      if (m_rt < 15) m_rt++;
    end
    m_el = 0;
    m_st = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_el = 0; m_st = 0;
      m_rt = 0; m_ls = 0;
      h1l = 0; h2l = 0; h1s = 0; h2s = 0;
    end else begin : step
      bit ok;
      ok = h2l & ~h2s;
      h2l = h1l; h1l = locked;
      h2s = h1s; h1s = status[2];
      case (m_ph)
        0: begin
          m_el++;
          if (m_el == RH) begin m_ph = 1; m_el = 0; end
        end
        1: begin
          if (ok) begin m_ph = 2; m_st = 1; m_el = 0; end
          else if (m_el + 1 == LT) m_failure();
          else m_el++;
        end
        2: begin
          if (!ok) m_failure();
          else begin
            m_st++;
            if (m_st == SC) begin
              m_ph = 3; m_rt = 0; m_st = 0;
            end
          end
        end
        3: begin
          if (!ok) begin
            if (m_ls < 255) m_ls++;
            m_failure();
          end
        end
        4: begin
          if (retry_req) begin
            m_ph = 0; m_el = 0; m_rt = 0;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked = 1'b0;
    status = 8'h00;
    retry_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({dcm_rst, sys_rst, ready, fail_flag} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 1100",
        {dcm_rst, sys_rst, ready, fail_flag});
    end
    n_chk++;
    if ({retry_cnt, loss_cnt, state} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got r=%0d l=%0d s=%0d want 0",
        retry_cnt, loss_cnt, state);
    end
  endtask

  task automatic test_nominal();
    int hi;
    int n;
    do_reset();
    hi = 0;
    n = 0;
    while (dcm_rst && n < 10) begin
      hi++;
      tick();
      n++;
    end
    n_chk++;
    if (hi != RH) begin
      n_fail++;
      $display("FAIL nom_dcm_hold got %0d want %0d", hi, RH);
    end
    for (int i = n; i < 5; i++) tick();
    locked = 1'b1;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    n_chk++;
    if (n != 2 + SC) begin
      n_fail++;
      $display("FAIL nom_latency got %0d want %0d", n, 2 + SC);
    end
    n_chk++;
    if ({sys_rst, dcm_rst, retry_cnt, state} !== {2'b00, 4'd0, 3'd3}) begin
      n_fail++;
      $display("FAIL nom_run got sys=%b dcm=%b r=%0d s=%0d want 0 0 0 3",
        sys_rst, dcm_rst, retry_cnt, state);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    n = 0;
    while (!fail_flag && n < 200) begin
      tick();
      n++;
      if (n == RH + LT || n == 2 * (RH + LT)) begin
        n_chk++;
        if (retry_cnt !== 4'(n / (RH + LT)) || state !== 3'd0) begin
          n_fail++;
          $display("FAIL to_retry at %0d got r=%0d s=%0d want r=%0d s=0",
            n, retry_cnt, state, n / (RH + LT));
        end
      end
    end
    n_chk++;
    if (n != 3 * (RH + LT)) begin
      n_fail++;
      $display("FAIL to_fail_time got %0d want %0d", n, 3 * (RH + LT));
    end
    n_chk++;
    if ({state, dcm_rst, sys_rst, retry_cnt} !== {3'd4, 2'b11, 4'd2}) begin
      n_fail++;
      $display("FAIL to_fail_state got s=%0d d=%b y=%b r=%0d want 4 1 1 2",
        state, dcm_rst, sys_rst, retry_cnt);
    end
    locked = 1'b1;
    repeat (6) tick();
    n_chk++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL to_fail_ignores_lock got s=%0d want 4", state);
    end
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    n_chk++;
    if ({state, retry_cnt, fail_flag} !== {3'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL to_retry_req got s=%0d r=%0d f=%b want 0 0 0",
        state, retry_cnt, fail_flag);
    end
  endtask

  task automatic test_settle_glitch();
    int n;
    do_reset();
    repeat (4) tick();
    locked = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 10) begin tick(); n++; end
    locked = 1'b0;
    tick();
    tick();
    locked = 1'b1;
    tick();
    n_chk++;
    if ({state, retry_cnt, dcm_rst} !== {3'd0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL glitch_hold got s=%0d r=%0d d=%b want 0 1 1",
        state, retry_cnt, dcm_rst);
    end
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    n_chk++;
    if ({state, retry_cnt} !== {3'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL glitch_rerun got s=%0d r=%0d want 3 0",
        state, retry_cnt);
    end
  endtask

  task automatic test_loss_in_run();
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) status = 8'h04;
      else locked = 1'b0;
      n = 0;
      while (!sys_rst && n < 10) begin tick(); n++; end
      n_chk++;
      if (n != 3) begin
        n_fail++;
        $display("FAIL loss_delay%0d got %0d want 3", k, n);
      end
      n_chk++;
      if ({dcm_rst, ready, loss_cnt, retry_cnt, state} !==
          {2'b10, 8'(k + 1), 4'd1, 3'd0}) begin
        n_fail++;
        $display("FAIL loss_edge%0d got d=%b l=%0d r=%0d s=%0d want 1 %0d 1 0",
          k, dcm_rst, loss_cnt, retry_cnt, state, k + 1);
      end
      status = 8'h00;
      locked = 1'b1;
      n = 0;
      while (!ready && n < 60) begin tick(); n++; end
      n_chk++;
      if ({state, retry_cnt, loss_cnt} !== {3'd3, 4'd0, 8'(k + 1)}) begin
        n_fail++;
        $display("FAIL loss_reseq%0d got s=%0d r=%0d l=%0d want 3 0 %0d",
          k, state, retry_cnt, loss_cnt, k + 1);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    locked = 1'b1;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    locked = 1'b0;
    n = 0;
    while (!(state === 3'd1 && retry_cnt === 4'd1) && n < 40) begin
      tick();
      n++;
    end
    tick();
    n_chk++;
    if ({state, loss_cnt} !== {3'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL async_pre got s=%0d l=%0d want 1 1", state, loss_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({dcm_rst, sys_rst, ready, fail_flag, state, retry_cnt, loss_cnt}
        !== {4'b1100, 3'd0, 4'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL async_clear got d=%b y=%b s=%0d r=%0d l=%0d want 1 1 0 0 0",
        dcm_rst, sys_rst, state, retry_cnt, loss_cnt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_boundaries();
    int n;
    do_reset();
    repeat (20) tick();
    locked = 1'b1;
    tick();
    tick();
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL bnd_pre got s=%0d want 1", state);
    end
    tick();
    n_chk++;
    if ({state, retry_cnt} !== {3'd2, 4'd0}) begin
      n_fail++;
      $display("FAIL bnd_last_cycle got s=%0d r=%0d want 2 0",
        state, retry_cnt);
    end
    do_reset();
    repeat (21) tick();
    locked = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({state, retry_cnt} !== {3'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL bnd_too_late got s=%0d r=%0d want 0 1",
        state, retry_cnt);
    end
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    tick();
    n_chk++;
    if ({state, ready, retry_cnt} !== {3'd3, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL bnd_req_in_run got s=%0d rdy=%b r=%0d want 3 1 0",
        state, ready, retry_cnt);
    end
  endtask

  task automatic test_random();
    logic [17:0] got;
    logic [17:0] exp;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (locked) begin
        if ($urandom_range(0, 39) == 0) locked = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) locked = 1'b1;
      end
      status[7:3] = 5'($urandom);
      status[1:0] = 2'($urandom);
      if (status[2]) begin
        if ($urandom_range(0, 3) == 0) status[2] = 1'b0;
      end else begin
        if ($urandom_range(0, 149) == 0) status[2] = 1'b1;
      end
      retry_req = ($urandom_range(0, 15) == 0);
      tick();
      got = {dcm_rst, sys_rst, ready, fail_flag,
             retry_cnt, loss_cnt, state};
      exp = {(m_ph == 0 || m_ph == 4), (m_ph != 3),
             (m_ph == 3), (m_ph == 4),
             4'(m_rt), 8'(m_ls), 3'(m_ph)};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got %h want %h", i, got, exp);
      end
    end
    retry_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_settle_glitch();
    test_loss_in_run();
    test_async_reset();
    test_boundaries();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
